// File: rtl/id_exe_reg_pkg.sv
// Shared types and constants for the ID/EXE pipeline register.
// Optional forwarding-source fields are enabled with ID_EXE_FWD_SRC_EN.
package id_exe_reg_pkg;

    localparam int unsigned PC_W     = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned SHIFT_W  = 12;
    localparam int unsigned IMM24_W  = 24;
    localparam int unsigned REG_W    = 4;
    localparam int unsigned CMD_W    = 4;
    localparam int unsigned STATUS_W = 4;
    localparam int unsigned CNT_W    = 16;

    // ALU command encodings carried through EXE
    typedef enum logic [CMD_W-1:0] {
        EXE_NOP = 4'h0,
        EXE_MOV = 4'h1,
        EXE_ADD = 4'h2,
        EXE_ADC = 4'h3,
        EXE_SUB = 4'h4,
        EXE_SBC = 4'h5,
        EXE_AND = 4'h6,
        EXE_ORR = 4'h7,
        EXE_EOR = 4'h8,
        EXE_MVN = 4'h9
    } exe_cmd_e;

    // Control values forced into the stage when a bubble is inserted
    typedef struct packed {
        logic             wb_en;
        logic             mem_r;
        logic             mem_w;
        logic             b;
        logic             s;
        logic             imm;
        logic             ld_str;
        logic [CMD_W-1:0] exe_cmd;
    } bubble_ctrl_t;

    localparam bubble_ctrl_t BUBBLE_CTRL = '{
        wb_en:   1'b0,
        mem_r:   1'b0,
        mem_w:   1'b0,
        b:       1'b0,
        s:       1'b0,
        imm:     1'b0,
        ld_str:  1'b0,
        exe_cmd: EXE_NOP
    };

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit saturating event counter with hold and synchronous clear.
// clr together with inc yields 1 so the coincident event is not lost.
module sat_counter16
    import id_exe_reg_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    input  logic             hold,
    output logic [CNT_W-1:0] count
);

    // Count register: hold beats clear, clear beats plain increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (!hold) begin
            if (clr) begin
                count <= inc ? CNT_W'(1) : '0;
            end else if (inc) begin
                count <= sat_inc(count);
            end
        end
    end

endmodule

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register with freeze, bubble insertion and bubble counter.
// Define ID_EXE_FWD_SRC_EN to carry forwarding source register fields.
module id_exe_reg
    import id_exe_reg_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze,
    input  logic                flush,
    input  logic                hazard,
    input  logic                clr_cnt,
    input  logic [PC_W-1:0]     pc_in,
    input  logic [DATA_W-1:0]   val_rn_in,
    input  logic [DATA_W-1:0]   val_rm_in,
    input  logic [SHIFT_W-1:0]  shift_operand_in,
    input  logic                imm_in,
    input  logic                ld_str_in,
    input  logic                s_in,
    input  logic                b_in,
    input  logic                mem_r_in,
    input  logic                mem_w_in,
    input  logic                wb_en_in,
    input  logic [CMD_W-1:0]    exe_cmd_in,
    input  logic [REG_W-1:0]    dest_in,
    input  logic [IMM24_W-1:0]  imm24_in,
    input  logic [STATUS_W-1:0] status_in,
`ifdef ID_EXE_FWD_SRC_EN
    input  logic [REG_W-1:0]    src1_in,
    input  logic [REG_W-1:0]    src2_in,
    input  logic                use_src2_in,
    output logic [REG_W-1:0]    src1_out,
    output logic [REG_W-1:0]    src2_out,
    output logic                use_src2_out,
`endif
    output logic [PC_W-1:0]     pc_out,
    output logic [DATA_W-1:0]   val_rn_out,
    output logic [DATA_W-1:0]   val_rm_out,
    output logic [SHIFT_W-1:0]  shift_operand_out,
    output logic                imm_out,
    output logic                ld_str_out,
    output logic                s_out,
    output logic                b_out,
    output logic                mem_r_out,
    output logic                mem_w_out,
    output logic                wb_en_out,
    output logic [CMD_W-1:0]    exe_cmd_out,
    output logic [REG_W-1:0]    dest_out,
    output logic [IMM24_W-1:0]  imm24_out,
    output logic [STATUS_W-1:0] status_out,
    output logic                valid_out,
    output logic [CNT_W-1:0]    bubble_cnt
);

    logic bubble;

    // flush and hazard collapse into a single bubble request
    assign bubble = flush | hazard;

    // Stage registers: freeze holds, bubble zeroes, otherwise load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_out            <= '0;
            val_rn_out        <= '0;
            val_rm_out        <= '0;
            shift_operand_out <= '0;
            imm_out           <= 1'b0;
            ld_str_out        <= 1'b0;
            s_out             <= 1'b0;
            b_out             <= 1'b0;
            mem_r_out         <= 1'b0;
            mem_w_out         <= 1'b0;
            wb_en_out         <= 1'b0;
            exe_cmd_out       <= '0;
            dest_out          <= '0;
            imm24_out         <= '0;
            status_out        <= '0;
`ifdef ID_EXE_FWD_SRC_EN
            src1_out          <= '0;
            src2_out          <= '0;
            use_src2_out      <= 1'b0;
`endif
            valid_out         <= 1'b0;
        end else if (!freeze) begin
            pc_out            <= bubble ? '0 : pc_in;
            val_rn_out        <= bubble ? '0 : val_rn_in;
            val_rm_out        <= bubble ? '0 : val_rm_in;
            shift_operand_out <= bubble ? '0 : shift_operand_in;
            imm_out           <= bubble ? BUBBLE_CTRL.imm    : imm_in;
            ld_str_out        <= bubble ? BUBBLE_CTRL.ld_str : ld_str_in;
            s_out             <= bubble ? BUBBLE_CTRL.s      : s_in;
            b_out             <= bubble ? BUBBLE_CTRL.b      : b_in;
            mem_r_out         <= bubble ? BUBBLE_CTRL.mem_r  : mem_r_in;
            mem_w_out         <= bubble ? BUBBLE_CTRL.mem_w  : mem_w_in;
            wb_en_out         <= bubble ? BUBBLE_CTRL.wb_en  : wb_en_in;
            exe_cmd_out       <= bubble ? BUBBLE_CTRL.exe_cmd : exe_cmd_in;
            dest_out          <= bubble ? '0 : dest_in;
            imm24_out         <= bubble ? '0 : imm24_in;
            status_out        <= bubble ? '0 : status_in;
`ifdef ID_EXE_FWD_SRC_EN
            src1_out          <= bubble ? '0 : src1_in;
            src2_out          <= bubble ? '0 : src2_in;
            use_src2_out      <= bubble ? 1'b0 : use_src2_in;
`endif
            valid_out         <= ~bubble;
        end
    end

    // Bubble counter frozen along with the rest of the stage
    sat_counter16 u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (bubble),
        .clr   (clr_cnt),
        .hold  (freeze),
        .count (bubble_cnt)
    );

endmodule

// File: tb/tb_id_exe_reg.sv
// Scoreboard bench for id_exe_reg: the driver queues hand-computed expected
// outputs, a monitor pops and compares after each edge or async probe.
// Works with or without ID_EXE_FWD_SRC_EN defined.
module tb_id_exe_reg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rn;
        logic [31:0] rm;
        logic [11:0] shift;
        logic        imm;
        logic        ld_str;
        logic        s;
        logic        b;
        logic        mem_r;
        logic        mem_w;
        logic        wb_en;
        logic [3:0]  exe_cmd;
        logic [3:0]  dest;
        logic [23:0] imm24;
        logic [3:0]  status;
`ifdef ID_EXE_FWD_SRC_EN
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic        use_src2;
`endif
    } fields_t;

    typedef struct {
        string       name;
        fields_t     f;
        logic        valid;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, freeze, flush, hazard, clr_cnt;
    logic        probe;
    fields_t     in_f;
    fields_t     act_f;
    logic        valid_out;
    logic [15:0] bubble_cnt;
    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;

    fields_t VA, VB, VC, VD, ZERO;

    always #5 clk = ~clk;

    id_exe_reg dut (
        .clk               (clk),
        .rst               (rst),
        .freeze            (freeze),
        .flush             (flush),
        .hazard            (hazard),
        .clr_cnt           (clr_cnt),
        .pc_in             (in_f.pc),
        .val_rn_in         (in_f.rn),
        .val_rm_in         (in_f.rm),
        .shift_operand_in  (in_f.shift),
        .imm_in            (in_f.imm),
        .ld_str_in         (in_f.ld_str),
        .s_in              (in_f.s),
        .b_in              (in_f.b),
        .mem_r_in          (in_f.mem_r),
        .mem_w_in          (in_f.mem_w),
        .wb_en_in          (in_f.wb_en),
        .exe_cmd_in        (in_f.exe_cmd),
        .dest_in           (in_f.dest),
        .imm24_in          (in_f.imm24),
        .status_in         (in_f.status),
`ifdef ID_EXE_FWD_SRC_EN
        .src1_in           (in_f.src1),
        .src2_in           (in_f.src2),
        .use_src2_in       (in_f.use_src2),
        .src1_out          (act_f.src1),
        .src2_out          (act_f.src2),
        .use_src2_out      (act_f.use_src2),
`endif
        .pc_out            (act_f.pc),
        .val_rn_out        (act_f.rn),
        .val_rm_out        (act_f.rm),
        .shift_operand_out (act_f.shift),
        .imm_out           (act_f.imm),
        .ld_str_out        (act_f.ld_str),
        .s_out             (act_f.s),
        .b_out             (act_f.b),
        .mem_r_out         (act_f.mem_r),
        .mem_w_out         (act_f.mem_w),
        .wb_en_out         (act_f.wb_en),
        .exe_cmd_out       (act_f.exe_cmd),
        .dest_out          (act_f.dest),
        .imm24_out         (act_f.imm24),
        .status_out        (act_f.status),
        .valid_out         (valid_out),
        .bubble_cnt        (bubble_cnt)
    );

    // Build a directed input vector; flags = {imm,ld_str,s,b,mem_r,mem_w,wb_en}
    function automatic fields_t mk(input logic [31:0] pc, input logic [31:0] rn,
                                   input logic [31:0] rm, input logic [11:0] shift,
                                   input logic [6:0] flags, input logic [3:0] cmd,
                                   input logic [3:0] dest, input logic [23:0] imm24,
                                   input logic [3:0] status, input logic [3:0] s1,
                                   input logic [3:0] s2, input logic us2);
        fields_t r;
        r = '0;
        r.pc = pc; r.rn = rn; r.rm = rm; r.shift = shift;
        {r.imm, r.ld_str, r.s, r.b, r.mem_r, r.mem_w, r.wb_en} = flags;
        r.exe_cmd = cmd; r.dest = dest; r.imm24 = imm24; r.status = status;
`ifdef ID_EXE_FWD_SRC_EN
        r.src1 = s1; r.src2 = s2; r.use_src2 = us2;
`else
        if (s1 != 4'd0 || s2 != 4'd0 || us2) r.status = status;
`endif
        return r;
    endfunction

    task automatic expect_out(input string nm, input fields_t f, input logic v,
                              input logic [15:0] c);
        exp_t e;
        e.name = nm; e.f = f; e.valid = v; e.cnt = c;
        sb.push_back(e);
    endtask

    // One clock: drive at negedge, optionally queue expectation for next edge
    task automatic cyc(input string nm, input logic fz, input logic fl,
                       input logic hz, input logic cl, input fields_t din,
                       input logic chk, input fields_t ef, input logic ev,
                       input logic [15:0] ec);
        @(negedge clk);
        freeze = fz; flush = fl; hazard = hz; clr_cnt = cl; in_f = din;
        if (chk) expect_out(nm, ef, ev, ec);
        @(posedge clk);
    endtask

    // Monitor: compare queued expectation after every edge or async probe
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or posedge probe);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if ({act_f, valid_out, bubble_cnt} !== {e.f, e.valid, e.cnt}) begin
                    errors++;
                    $display("FAIL %s: got fields=%h valid=%b cnt=%h, expected fields=%h valid=%b cnt=%h",
                             e.name, act_f, valid_out, bubble_cnt, e.f, e.valid, e.cnt);
                end
            end
        end
    end

    initial begin
        ZERO = '0;
        VA = mk(32'h0000_0010, 32'h1111_0001, 32'h2222_0002, 12'hABC, 7'b1010011,
                4'h2, 4'h3, 24'h80_0001, 4'hA, 4'd5, 4'd9, 1'b1);
        VB = mk(32'hDEAD_BEE0, 32'hFFFF_FFFF, 32'h8000_0000, 12'hFFF, 7'b1111111,
                4'hF, 4'hF, 24'hFF_FFFF, 4'hF, 4'd15, 4'd15, 1'b1);
        VC = mk(32'h0000_0400, 32'h0000_0007, 32'h0000_0008, 12'h001, 7'b0101100,
                4'h4, 4'h1, 24'h00_0010, 4'h6, 4'd2, 4'd3, 1'b0);
        VD = mk(32'h1234_5678, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 12'h5A5, 7'b0000101,
                4'h9, 4'hE, 24'h7F_FFFF, 4'h1, 4'd7, 4'd0, 1'b1);

        rst = 1'b0; freeze = 1'b0; flush = 1'b0; hazard = 1'b0; clr_cnt = 1'b0;
        probe = 1'b0; in_f = VB;

        // Async reset with nonzero inputs, sampled before any clock edge
        #1 rst = 1'b1;
        #1 expect_out("reset_async", ZERO, 1'b0, 16'd0);
        probe = 1'b1;
        #2 probe = 1'b0;

        cyc("reset_hold", 1'b0, 1'b0, 1'b0, 1'b0, VB, 1'b1, ZERO, 1'b0, 16'd0);
        #2 rst = 1'b0;

        cyc("load_a", 1'b0, 1'b0, 1'b0, 1'b0, VA, 1'b1, VA, 1'b1, 16'd0);
        cyc("load_b", 1'b0, 1'b0, 1'b0, 1'b0, VB, 1'b1, VB, 1'b1, 16'd0);
        for (int i = 0; i < 3; i++)
            cyc("freeze_flush", 1'b1, 1'b1, 1'b1, 1'b1, VC, 1'b1, VB, 1'b1, 16'd0);
        cyc("hazard_bubble", 1'b0, 1'b0, 1'b1, 1'b0, VC, 1'b1, ZERO, 1'b0, 16'd1);
        cyc("bubble_repeat", 1'b0, 1'b0, 1'b1, 1'b0, VD, 1'b1, ZERO, 1'b0, 16'd2);
        cyc("load_c", 1'b0, 1'b0, 1'b0, 1'b0, VC, 1'b1, VC, 1'b1, 16'd2);
        cyc("flush_hazard", 1'b0, 1'b1, 1'b1, 1'b0, VA, 1'b1, ZERO, 1'b0, 16'd3);
        cyc("clr_load", 1'b0, 1'b0, 1'b0, 1'b1, VD, 1'b1, VD, 1'b1, 16'd0);

        // Reset in the middle of a frozen bubble request wins at once
        @(negedge clk);
        freeze = 1'b1; hazard = 1'b1; flush = 1'b0; clr_cnt = 1'b0; in_f = VA;
        #2 rst = 1'b1;
        expect_out("reset_mid", ZERO, 1'b0, 16'd0);
        probe = 1'b1;
        #1 probe = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;

        cyc("post_release", 1'b0, 1'b0, 1'b1, 1'b0, VA, 1'b1, ZERO, 1'b0, 16'd1);
        cyc("load_e", 1'b0, 1'b0, 1'b0, 1'b0, VA, 1'b1, VA, 1'b1, 16'd1);

        // 65537 bubble edges in total; only the last one is checked
        for (int i = 0; i < 65536; i++)
            cyc("sat_run", 1'b0, 1'b1, 1'b0, 1'b0, VB, 1'b0, ZERO, 1'b0, 16'd0);
        cyc("saturate", 1'b0, 1'b0, 1'b1, 1'b0, VB, 1'b1, ZERO, 1'b0, 16'hFFFF);
        cyc("clr_bubble", 1'b0, 1'b0, 1'b1, 1'b1, VB, 1'b1, ZERO, 1'b0, 16'd1);
        cyc("clr_only", 1'b0, 1'b0, 1'b0, 1'b1, VB, 1'b1, VB, 1'b1, 16'd0);

        cyc("idle", 1'b0, 1'b0, 1'b0, 1'b0, VB, 1'b0, ZERO, 1'b0, 16'd0);
        #2;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
